// File: rtl/inert_rd_sequencer_pkg.sv
// Shared definitions for the inertial read sequencer and the integrator:
// FSM state encoding and the IMU SPI command words.
package inert_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    CFG0,
    CFG1,
    CFG2,
    CFG3,
    IDLE,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH,
    VLD
  } state_t;

  // Configuration writes, issued in this order after power-up
  localparam logic [15:0] CMD_CFG_INT = 16'h0D02;
  localparam logic [15:0] CMD_CFG_ACC = 16'h1053;
  localparam logic [15:0] CMD_CFG_GYR = 16'h1150;
  localparam logic [15:0] CMD_CFG_RND = 16'h1460;

  // Reads set bit 15; the low byte is a don't-care driven to zero
  localparam logic [15:0] CMD_RD_PL = 16'hA200;
  localparam logic [15:0] CMD_RD_PH = 16'hA300;
  localparam logic [15:0] CMD_RD_AL = 16'hAC00;
  localparam logic [15:0] CMD_RD_AH = 16'hAD00;

  // Gyro zero-rate bias removed by the integrator
  localparam logic signed [15:0] PTCH_RT_OFFSET = 16'sh0032;

endpackage

// File: rtl/inert_rd_sequencer_if.sv
// SPI master handshake: master = command issuer (sequencer), slave = SPI engine.
interface inert_rd_sequencer_if;

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);

endinterface

// File: rtl/inert_int_sync.sv
// Synchronizes the IMU data-ready interrupt, detects its rising edge and keeps
// a one-deep pending request for edges that arrive while the sequencer is busy.
module inert_int_sync (
  input  logic clk,
  input  logic rst,
  input  logic int_async,
  input  logic idle,
  output logic req
);

  logic int_ff1, int_ff2, int_ff3;
  logic rise;
  logic pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
      int_ff3 <= 1'b0;
    end else begin
      int_ff1 <= int_async;
      int_ff2 <= int_ff1;
      int_ff3 <= int_ff2;
    end
  end

  assign rise = int_ff2 & ~int_ff3;

  // IDLE always consumes the request, so pending only survives outside IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= 1'b0;
    else if (idle)
      pending <= 1'b0;
    else if (rise)
      pending <= 1'b1;
  end

  assign req = rise | pending;

endmodule

// File: rtl/inert_rd_sequencer.sv
// Power-up wait, IMU configuration and per-interrupt four-byte read burst;
// presents a coherent signed pitch-rate / Z-accel pair with a vld pulse.
module inert_rd_sequencer #(
  parameter int PWRUP_BITS = 16,
  parameter bit FAST_SIM   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 INT,
  inert_rd_sequencer_if.master spi,
  output logic [15:0]          ptch_rt,
  output logic [15:0]          AZ,
  output logic                 vld
);

  import inert_pkg::*;

  localparam int CNT_W = FAST_SIM ? 6 : PWRUP_BITS;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             wrt_q, wrt_nxt;
  logic [15:0]      cmd_q, cmd_nxt;
  logic [7:0]       ptch_lo, ptch_hi, az_lo;
  logic             req;
  logic [7:0]       unused_rd_hi;

  inert_int_sync u_int_sync (
    .clk       (clk),
    .rst       (rst),
    .int_async (INT),
    .idle      (state == IDLE),
    .req       (req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PWRUP;
      cnt   <= '0;
      wrt_q <= 1'b0;
      cmd_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      cnt   <= (state == PWRUP) ? cnt + 1'b1 : '0;
      wrt_q <= wrt_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  // wrt/cmd are registered, so each wrt lands one cycle after the decision
  always_comb begin
    state_nxt = state;
    wrt_nxt   = 1'b0;
    cmd_nxt   = cmd_q;
    case (state)
      PWRUP: if (&cnt) begin wrt_nxt = 1'b1; cmd_nxt = CMD_CFG_INT; state_nxt = CFG0; end
      CFG0:  if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_CFG_ACC; state_nxt = CFG1; end
      CFG1:  if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_CFG_GYR; state_nxt = CFG2; end
      CFG2:  if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_CFG_RND; state_nxt = CFG3; end
      CFG3:  if (spi.done) state_nxt = IDLE;
      IDLE:  if (req) begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_PL; state_nxt = RD_PL; end
      RD_PL: if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_PH; state_nxt = RD_PH; end
      RD_PH: if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_AL; state_nxt = RD_AL; end
      RD_AL: if (spi.done) begin wrt_nxt = 1'b1; cmd_nxt = CMD_RD_AH; state_nxt = RD_AH; end
      RD_AH: if (spi.done) state_nxt = VLD;
      VLD:   state_nxt = IDLE;
      default: state_nxt = PWRUP;
    endcase
  end

  // The last byte goes straight into AZ so both outputs switch on the same
  // edge that enters VLD; nothing visible changes mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptch_lo <= 8'h00;
      ptch_hi <= 8'h00;
      az_lo   <= 8'h00;
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
    end else if (spi.done) begin
      case (state)
        RD_PL: ptch_lo <= spi.rd_data[7:0];
        RD_PH: ptch_hi <= spi.rd_data[7:0];
        RD_AL: az_lo   <= spi.rd_data[7:0];
        RD_AH: begin
          ptch_rt <= {ptch_hi, ptch_lo};
          AZ      <= {spi.rd_data[7:0], az_lo};
        end
        default: ;
      endcase
    end
  end

  assign vld          = (state == VLD);
  assign spi.wrt      = wrt_q;
  assign spi.cmd      = cmd_q;
  assign unused_rd_hi = spi.rd_data[15:8];

endmodule
